// File: rtl/sqrt_nonrestoring_param.sv
// Iterative non-restoring integer square root, one root bit per cycle.
// Ports: clk, clr (sync reset), start/abort/d in; q/r results, busy, ready out.
module sqrt_nonrestoring_param #(
  parameter  int WIDTH = 32,
  localparam int QW    = WIDTH / 2,
  localparam int RW    = WIDTH / 2 + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] d,
  output logic [QW-1:0]    q,
  output logic [RW-1:0]    r,
  output logic             busy,
  output logic             ready
);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("sqrt_nonrestoring_param: WIDTH must be even and >= 4");
  end

  localparam int PW = QW + 2;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic [PW-1:0]    p_q, p_d;
  logic [QW-1:0]    root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [QW-1:0]    q_q, q_d;
  logic [RW-1:0]    r_q, r_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic [1:0]       dp;
  logic [PW-1:0]    p_sh;
  logic [PW-1:0]    p_calc;
  logic [RW-1:0]    r_fix;

  // P is two's complement; its MSB is the sign.
  assign dp     = d_sh_q[WIDTH-1 -: 2];
  assign p_sh   = {p_q[PW-3:0], dp};
  assign p_calc = p_q[PW-1] ? p_sh + {root_q, 2'b11}
                            : p_sh - {root_q, 2'b01};

  // Corrected remainder is non-negative and below 2^RW, so the
  // low RW bits of the sum are exact.
  assign r_fix  = p_q[RW-1:0]
                + (p_q[PW-1] ? {root_q, 1'b1} : {RW{1'b0}});

  always_comb begin
    state_d = state_q;
    d_sh_d  = d_sh_q;
    p_d     = p_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          d_sh_d  = d;
          p_d     = '0;
          root_d  = '0;
          cnt_d   = CW'(QW - 1);
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          d_sh_d = {d_sh_q[WIDTH-3:0], 2'b00};
          p_d    = p_calc;
          root_d = {root_q[QW-2:0], ~p_calc[PW-1]};
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!abort) begin
          q_d     = root_q;
          r_d     = r_fix;
          ready_d = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      d_sh_q  <= '0;
      p_q     <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_sh_q  <= d_sh_d;
      p_q     <= p_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign q     = q_q;
  assign r     = r_q;
  assign busy  = busy_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_sqrt_nonrestoring_param.sv
// Bench for sqrt_nonrestoring_param at WIDTH 32, 8 and 16.
// Scoreboard queues hold expected results; monitors compare on ready.
module tb_sqrt_nonrestoring_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr;

  logic        st32, ab32, bz32, rdy32;
  logic [31:0] d32;
  logic [15:0] q32;
  logic [16:0] r32;

  logic        st8, ab8, bz8, rdy8;
  logic [7:0]  d8;
  logic [3:0]  q8;
  logic [4:0]  r8;

  logic        st16, ab16, bz16, rdy16;
  logic [15:0] d16;
  logic [7:0]  q16;
  logic [8:0]  r16;

  sqrt_nonrestoring_param #(.WIDTH(32)) u32 (
    .clk(clk), .clr(clr), .start(st32), .abort(ab32), .d(d32),
    .q(q32), .r(r32), .busy(bz32), .ready(rdy32)
  );
  sqrt_nonrestoring_param #(.WIDTH(8)) u8 (
    .clk(clk), .clr(clr), .start(st8), .abort(ab8), .d(d8),
    .q(q8), .r(r8), .busy(bz8), .ready(rdy8)
  );
  sqrt_nonrestoring_param #(.WIDTH(16)) u16 (
    .clk(clk), .clr(clr), .start(st16), .abort(ab16), .d(d16),
    .q(q16), .r(r16), .busy(bz16), .ready(rdy16)
  );

  typedef struct {
    longint unsigned d;
    longint unsigned q;
    longint unsigned r;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];
  exp_t sb16[$];

  int n_chk = 0;
  int n_err = 0;
  int nr32  = 0;

  function automatic longint unsigned isqrt(longint unsigned v);
    longint unsigned s, t;
    s = 0;
    for (int b = 31; b >= 0; b--) begin
      t = s | (64'd1 << b);
      if (t * t <= v) s = t;
    end
    return s;
  endfunction

  function automatic exp_t mk(longint unsigned v);
    exp_t e;
    e.d = v;
    e.q = isqrt(v);
    e.r = v - e.q * e.q;
    return e;
  endfunction

  task automatic chk(string tag, longint unsigned obs,
                     longint unsigned exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(string tag, exp_t e,
                         longint unsigned qo, longint unsigned ro);
    chk({tag, "_q"}, qo, e.q);
    chk({tag, "_r"}, ro, e.r);
    chk({tag, "_qq_plus_r"}, qo * qo + ro, e.d);
    chk({tag, "_r_le_2q"}, (ro <= 2 * qo) ? 1 : 0, 1);
  endtask

  always @(negedge clk) begin
    if (rdy32 === 1'b1) begin
      nr32++;
      if (sb32.size() == 0) chk("ready32_unexpected", sb32.size(), 1);
      else chk_res("w32", sb32.pop_front(), q32, r32);
    end
  end

  always @(negedge clk) begin
    if (rdy8 === 1'b1) begin
      if (sb8.size() == 0) chk("ready8_unexpected", sb8.size(), 1);
      else chk_res("w8", sb8.pop_front(), q8, r8);
    end
  end

  always @(negedge clk) begin
    if (rdy16 === 1'b1) begin
      if (sb16.size() == 0) chk("ready16_unexpected", sb16.size(), 1);
      else chk_res("w16", sb16.pop_front(), q16, r16);
    end
  end

  task automatic issue32(input logic [31:0] v);
    d32  = v;
    st32 = 1'b1;
    sb32.push_back(mk(v));
  endtask

  task automatic issue8(input logic [7:0] v);
    d8  = v;
    st8 = 1'b1;
    sb8.push_back(mk(v));
  endtask

  task automatic issue16(input logic [15:0] v);
    d16  = v;
    st16 = 1'b1;
    sb16.push_back(mk(v));
  endtask

  // kind: 0 none, 1 stray start, 2 abort, 3 clr; applied for the
  // edge after 'at'. For kinds 2/3 return one cycle after it hits.
  task automatic wait32(input int at, input int kind,
                        output int lat, output int bz);
    lat = 0;
    bz  = 0;
    forever begin
      @(negedge clk);
      st32 = 1'b0;
      ab32 = 1'b0;
      clr  = 1'b0;
      d32  = $urandom;
      if (rdy32) break;
      if (kind >= 2 && lat == at + 1) break;
      if (lat >= 100) begin
        chk("ready32_timeout", rdy32, 1);
        break;
      end
      bz += int'(bz32);
      if (lat == at) begin
        case (kind)
          1: begin st32 = 1'b1; d32 = 32'd100; end
          2: ab32 = 1'b1;
          3: clr  = 1'b1;
          default: ;
        endcase
      end
      lat++;
    end
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      st8 = 1'b0;
      d8  = 8'($urandom);
      if (rdy8) break;
      if (lat >= 100) begin
        chk("ready8_timeout", rdy8, 1);
        break;
      end
      lat++;
    end
  endtask

  task automatic wait16(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      st16 = 1'b0;
      d16  = 16'($urandom);
      if (rdy16) break;
      if (lat >= 100) begin
        chk("ready16_timeout", rdy16, 1);
        break;
      end
      lat++;
    end
  endtask

  initial begin
    int lat, bz, n0;
    exp_t dropped;
    clr  = 1'b1;
    st32 = 1'b0; ab32 = 1'b0; d32 = '0;
    st8  = 1'b0; ab8  = 1'b0; d8  = '0;
    st16 = 1'b0; ab16 = 1'b0; d16 = '0;
    repeat (3) @(negedge clk);
    chk("rst_q32", q32, 0);
    chk("rst_r32", r32, 0);
    chk("rst_busy32", bz32, 0);
    chk("rst_ready32", rdy32, 0);
    chk("rst_q8", q8, 0);
    chk("rst_busy8", bz8, 0);
    clr = 1'b0;
    @(negedge clk);

    issue32(32'd7000000);
    wait32(0, 0, lat, bz);
    chk("lat_7m", lat, 17);
    chk("busy_cycles_7m", bz, 17);

    issue32(32'd0);
    wait32(0, 0, lat, bz);
    chk("lat_b2b_0", lat, 17);
    issue32(32'd1);
    wait32(0, 0, lat, bz);
    chk("lat_b2b_1", lat, 17);
    issue32(32'hFFFF_FFFF);
    wait32(0, 0, lat, bz);
    chk("lat_b2b_max", lat, 17);
    @(negedge clk);
    chk("ready_pulse_width", rdy32, 0);
    chk("busy_after_done", bz32, 0);
    chk("q_held_max", q32, 65535);
    chk("r_held_max", r32, 131070);

    issue8(8'd200);
    wait8(lat);
    chk("lat8_200", lat, 5);
    issue8(8'd255);
    wait8(lat);
    chk("lat8_255", lat, 5);

    @(negedge clk);
    n0 = nr32;
    issue32(32'd7000000);
    wait32(5, 1, lat, bz);
    chk("lat_stray_start", lat, 17);
    repeat (25) @(negedge clk);
    chk("stray_start_readies", nr32 - n0, 1);

    issue32(32'd144);
    wait32(0, 0, lat, bz);
    chk("lat_144", lat, 17);
    issue32(32'd7000000);
    wait32(8, 2, lat, bz);
    chk("abort_busy", bz32, 0);
    chk("abort_ready", rdy32, 0);
    chk("abort_q_kept", q32, 12);
    chk("abort_r_kept", r32, 0);
    dropped = sb32.pop_back();
    n0 = nr32;
    repeat (25) @(negedge clk);
    chk("abort_no_ready", nr32 - n0, 0);
    chk("abort_q_still", q32, 12);
    issue32(32'd7000000);
    wait32(0, 0, lat, bz);
    chk("lat_after_abort", lat, 17);

    @(negedge clk);
    issue32(32'd9999);
    wait32(10, 3, lat, bz);
    chk("clr_q", q32, 0);
    chk("clr_r", r32, 0);
    chk("clr_busy", bz32, 0);
    chk("clr_ready", rdy32, 0);
    dropped = sb32.pop_back();
    issue32(32'd144);
    wait32(0, 0, lat, bz);
    chk("lat_after_clr", lat, 17);

    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) issue16(16'd0);
      else if (i == 999) issue16(16'hFFFF);
      else issue16(16'($urandom));
      wait16(lat);
      chk("lat16", lat, 9);
    end

    repeat (5) @(negedge clk);
    chk("sb32_left", sb32.size(), 0);
    chk("sb8_left", sb8.size(), 0);
    chk("sb16_left", sb16.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
